// File: rtl/fir_ser_pkg.sv
// Shared definitions for the FIR decimating serializer: FSM encoding, default sizes, frame length.
// Frame length depends on FIR_SER_PARITY_EN (adds one even-parity bit after the LSB).
package fir_ser_pkg;

    localparam int DEF_BW_OUT     = 8;
    localparam int DEF_DECIM      = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_t;

    function automatic int frame_len(input int bw);
`ifdef FIR_SER_PARITY_EN
        return bw + 1;
`else
        return bw;
`endif
    endfunction

endpackage

// File: rtl/fir_ser_fifo.sv
// Small synchronous FIFO for kept samples; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module fir_ser_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally so a pop can load the shift register on the same edge.
    assign rdata = mem[rd_ptr_reg];
    assign level = level_reg;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fir_decim_serializer.sv
// Keeps every DECIM-th filter sample, queues it, and emits framed MSB-first serial words.
// Optional macro FIR_SER_PARITY_EN appends an even-parity bit to every frame.
module fir_decim_serializer
    import fir_ser_pkg::*;
#(
    parameter int BW_OUT     = DEF_BW_OUT,
    parameter int DECIM      = DEF_DECIM,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BW_OUT-1:0] in_data,
    input  logic              ser_ready,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              ser_start,
    output logic              overflow,
    output logic [LW-1:0]     fifo_level
);

    localparam int FRAME_LEN = frame_len(BW_OUT);
    localparam int BCW       = $clog2(FRAME_LEN);

    ser_state_t           state_reg, state_next;
    logic [8:0]           decim_cnt_reg;
    logic [FRAME_LEN-1:0] shreg_reg;
    logic [FRAME_LEN-1:0] load_word;
    logic [BCW-1:0]       bit_cnt_reg;
    logic                 overflow_reg;
    logic                 keep;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [BW_OUT-1:0]    fifo_rdata;

    assign keep = in_valid && (decim_cnt_reg == 9'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (reset)
            decim_cnt_reg <= '0;
        else if (in_valid)
            decim_cnt_reg <= keep ? '0 : decim_cnt_reg + 1'b1;
    end

    fir_ser_fifo #(
        .WIDTH (BW_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (keep),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A kept sample is only lost when the FIFO is full and nothing leaves this cycle.
    always_ff @(posedge clk) begin
        if (reset)
            overflow_reg <= 1'b0;
        else if (keep && fifo_full && !fifo_pop)
            overflow_reg <= 1'b1;
    end

`ifdef FIR_SER_PARITY_EN
    assign load_word = {fifo_rdata, ^fifo_rdata};
`else
    assign load_word = fifo_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && ser_ready) begin
                    state_next = ST_SHIFT;
                    fifo_pop   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_reg == BCW'(FRAME_LEN - 1))
                    state_next = ST_GAP;
            end
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (fifo_pop) begin
            shreg_reg   <= load_word;
            bit_cnt_reg <= '0;
        end else if (state_reg == ST_SHIFT) begin
            shreg_reg   <= shreg_reg << 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
    end

    // Serial outputs are decoded from registers only, so no input reaches them combinationally.
    assign ser_valid = (state_reg == ST_SHIFT);
    assign ser_data  = ser_valid && shreg_reg[FRAME_LEN-1];
    assign ser_start = ser_valid && (bit_cnt_reg == '0);
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fir_decim_serializer.sv
// Randomized scoreboard bench for fir_decim_serializer: a cycle-level queue model predicts
// kept samples, FIFO occupancy, overflow and frame contents; a monitor reassembles frames.
module tb_fir_decim_serializer;

    localparam int BW_OUT     = 8;
    localparam int DECIM      = 16;
    localparam int FIFO_DEPTH = 4;
`ifdef FIR_SER_PARITY_EN
    localparam int FRAME_LEN = BW_OUT + 1;
`else
    localparam int FRAME_LEN = BW_OUT;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       ser_ready = 1'b0;
    logic       ser_data;
    logic       ser_valid;
    logic       ser_start;
    logic       overflow;
    logic [2:0] fifo_level;

    fir_decim_serializer #(
        .BW_OUT     (BW_OUT),
        .DECIM      (DECIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_start  (ser_start),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] make_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++)
            ones += int'(d[i]);
`ifdef FIR_SER_PARITY_EN
        return {7'b0, d, 1'(ones % 2)};
`else
        return {8'b0, d};
`endif
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  mq[$];
    logic [15:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    int          cyc = 0;
    int          next_free = 0;

    always @(posedge clk) begin
        bit was_reset;
        bit m_pop;
        int pre;
        was_reset = reset;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            m_cnt     = 0;
            m_ovf     = 1'b0;
            next_free = cyc + 1;
        end else begin
            pre   = mq.size();
            m_pop = (cyc >= next_free) && (pre > 0) && ser_ready;
            if (m_pop) begin
                exp_q.push_back(make_frame(mq.pop_front()));
                next_free = cyc + FRAME_LEN + 2;
            end
            if (in_valid) begin
                if (m_cnt == DECIM - 1) begin
                    m_cnt = 0;
                    if (pre < FIFO_DEPTH || m_pop)
                        mq.push_back(in_data);
                    else
                        m_ovf = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
        cyc++;
        #1;
        if (was_reset) begin
            chk(ser_valid == 1'b0, "reset_ser_valid", 32'(ser_valid), 0);
            chk(ser_start == 1'b0, "reset_ser_start", 32'(ser_start), 0);
            chk(ser_data == 1'b0, "reset_ser_data", 32'(ser_data), 0);
        end
        chk(fifo_level == 3'(mq.size()), "fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk(overflow == m_ovf, "overflow", 32'(overflow), 32'(m_ovf));
    end

    // ---------------- monitor ----------------
    bit          mon_active = 1'b0;
    bit          gap_due = 1'b0;
    int          mon_bits = 0;
    logic [15:0] mon_word = '0;
    int          frames_seen = 0;

    always @(negedge clk) begin
        logic [15:0] exp_word;
        if (reset) begin
            mon_active = 1'b0;
            gap_due    = 1'b0;
        end else if (gap_due) begin
            chk(ser_valid == 1'b0, "gap_cycle", 32'(ser_valid), 0);
            gap_due = 1'b0;
        end else if (ser_valid) begin
            if (!mon_active) begin
                chk(ser_start == 1'b1, "start_first_bit", 32'(ser_start), 1);
                mon_active = 1'b1;
                mon_bits   = 0;
                mon_word   = '0;
            end else begin
                chk(ser_start == 1'b0, "start_mid_frame", 32'(ser_start), 0);
            end
            mon_word = {mon_word[14:0], ser_data};
            mon_bits++;
            if (mon_bits == FRAME_LEN) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_frame", 32'(mon_word), 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk(mon_word == exp_word, "frame", 32'(mon_word), 32'(exp_word));
                end
                frames_seen++;
                mon_active = 1'b0;
                gap_due    = 1'b1;
            end
        end else if (mon_active) begin
            chk(1'b0, "frame_truncated", 32'(mon_bits), 32'(FRAME_LEN));
            mon_active = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rst);
        @(posedge clk);
        #2;
        in_valid  = v;
        in_data   = d;
        ser_ready = r;
        reset     = rst;
    endtask

    task automatic feed(input int n, input logic r);
        for (int i = 0; i < n; i++)
            step(1'b1, 8'($urandom), r, 1'b0);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'($urandom), r, 1'b0);
    endtask

    initial begin
        int f0;
        // Reset held with in_valid active; nothing may be kept during it.
        reset    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'($urandom), 1'b1, 1'b1);

        // First kept sample is the 16th valid after reset; make it 8'hA5.
        feed(DECIM - 1, 1'b1);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        idle(FRAME_LEN + 6, 1'b1);
        chk(frames_seen == 1, "a5_frame_count", 32'(frames_seen), 1);
        feed(DECIM * 6, 1'b1);
        idle(20, 1'b1);

        // Back-pressure: fill, overflow on a fifth kept sample, then drain in order.
        feed(DECIM * 5, 1'b0);
        idle(4, 1'b0);
        f0 = frames_seen;
        idle(FIFO_DEPTH * (FRAME_LEN + 2) + 10, 1'b1);
        chk(frames_seen - f0 == FIFO_DEPTH, "drain_frames", 32'(frames_seen - f0), FIFO_DEPTH);

        // Full FIFO with a pop on the same edge as a new kept sample.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        feed(DECIM * FIFO_DEPTH + DECIM - 1, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b0);
        idle((FIFO_DEPTH + 1) * (FRAME_LEN + 2) + 10, 1'b1);

        // Reset in the middle of an 8'hFF frame.
        step(1'b0, 8'h00, 1'b1, 1'b1);
        feed(DECIM - 1, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        f0 = frames_seen;
        feed(DECIM - 1, 1'b1);
        idle(FRAME_LEN + 4, 1'b1);
        chk(frames_seen == f0, "no_frame_before_decim", 32'(frames_seen), 32'(f0));

        // Parity / plain frame of 8'h07.
        step(1'b1, 8'h07, 1'b1, 1'b0);
        idle(FRAME_LEN + 6, 1'b1);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) < 7), 1'b0);
        idle(FIFO_DEPTH * (FRAME_LEN + 2) + 20, 1'b1);
        chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 0);
        chk(mq.size() == 0 && fifo_level == 0, "fifo_drained", 32'(fifo_level), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
